ls_buffer: RTL and testbench
============================

# ls_buffer

In-order load/store queue between the dispatcher and the LS unit of the Tomasulo core. Holds dispatched memory instructions with their base and store-data operands, snoops both CDB ports to capture operand values still in flight, and issues the head entry to LS once it is ready and LS is free. Memory ordering is preserved by issuing strictly from the head.

## Interface
- DEPTH, 8: queue entries, power of two.
- DATA_W, 32: operand and immediate width.
- TAG_W, 4: reservation tag width. Tag 0 means no tag, i.e. the value is ready.
- NAME_W, 5: destination register name width.
- OP_W, 6: opcode width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enDispatch  in  1  dispatcher writes one entry this cycle.
- opCodeIn  in  OP_W  memory opcode.
- operandOIn / operandTIn  in  DATA_W  base / store-data value; valid when the matching tag is 0.
- tagOIn / tagTIn  in  TAG_W  producer tag of each operand; 0 means ready.
- immIn  in  DATA_W  offset.
- wrtTagIn  in  TAG_W  tag of the result.
- wrtNameIn  in  NAME_W  destination register.
- aluCDBen / lsCDBen  in  1  broadcast valid on the ALU / LS CDB.
- aluCDBtag / lsCDBtag  in  TAG_W  broadcast tag.
- aluCDBdata / lsCDBdata  in  DATA_W  broadcast value.
- LSfree  in  1  LS can accept an instruction.
- lsbFull  out  1  occupancy equals DEPTH.
- LSworkEn  out  1  one-cycle issue strobe to LS.
- operandO / operandT / imm  out  DATA_W  issued base, store data and offset.
- wrtTag  out  TAG_W  issued result tag.
- wrtName  out  NAME_W  issued destination.
- opCode  out  OP_W  issued opcode.

## Operation
- Storage is a circular buffer with head and tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Each entry holds: valid, opCode, valO, tagO, valT, tagT, imm, wrtTag, wrtName.
- **Dispatch:**
  - When enDispatch=1 and lsbFull=0, the entry is written at tail and tail increments.
  - When enDispatch=1 and lsbFull=1, the write is dropped and there is no state change.
  - lsbFull is combinational from the registered count, so it is evaluated before any same-cycle issue.
- **Snoop:** every cycle, for each valid entry and each operand with tag≠0:
  - if aluCDBen=1 and the tag matches aluCDBtag, the operand captures aluCDBdata and its tag becomes 0; the LS port is handled the same way.
  - If both ports match the same tag, the ALU value is captured. Tags are unique, so this case is a bench-only check.
- **Dispatch-time capture:** if an incoming tagOIn or tagTIn matches a broadcast in the same cycle, the entry is written with the broadcast value and tag 0.
- **Issue condition:** head is valid, head tagO=0 and tagT=0, LSfree=1, and LSworkEn=0 in the current cycle.
  - The last term leaves a one-cycle gap, so LS has time to drop LSfree.
  - When the condition holds, LSworkEn is registered high and the payload is registered from head. Head invalidates, head increments, and count decrements.
- **Readiness:** the snoop update and the ready check are not bypassed. A head that becomes ready through a CDB capture at edge t can issue at edge t+1 at the earliest.
- **Simultaneous dispatch and issue:** count is unchanged and both pointers advance.
- **Empty buffer:** no issue takes place and LSworkEn stays 0.

## Timing
- **Reset values** (asynchronous on rst=0): all entries invalid, head=tail=count=0, lsbFull=0, LSworkEn=0, and every payload output 0.
- **Latency:** dispatch of a ready entry into an empty buffer at edge t, with LSfree=1, gives LSworkEn=1 in the cycle after edge t+1.
- **LSworkEn** is high for exactly one cycle per issue. Payload outputs hold their last issued values until the next issue.
- **Throughput:** at most one issue every two cycles.
- **Reset mid-operation:** all entries are discarded immediately. No LSworkEn is produced from pre-reset state.

## Test plan
- **Reset:** assert rst=0 mid-run with 3 entries queued → LSworkEn=0, lsbFull=0, all outputs 0. After release, no issue happens until a new dispatch.
- **Ready load:** dispatch opCode=LW, tagO=0, operandO=0x100, imm=4, wrtTag=3, wrtName=5, with LSfree=1 → LSworkEn pulses one cycle, two edges after dispatch, carrying operandO=0x100, imm=4, wrtTag=3, wrtName=5.
- **Waiting operand:** dispatch with tagO=7, then aluCDBen=1, aluCDBtag=7, aluCDBdata=0x2000 three cycles later → issue in the cycle after the next edge with operandO=0x2000.
- **Dispatch-time capture:** dispatch with tagT=9 while lsCDBen=1, lsCDBtag=9, lsCDBdata=0xDEAD → the entry issues with operandT=0xDEAD and no further broadcast is needed.
- **Full / wrap:** hold LSfree=0 and dispatch 9 entries → lsbFull=1 after 8 and the 9th is dropped. Then release LSfree=1 → 8 issues in FIFO order spaced two cycles apart, tail wraps correctly, and lsbFull clears after the first issue.
- **In-order blocking:** head waits on tag 4 and entry 2 is ready → no issue until tag 4 broadcasts, then head issues followed by entry 2.

Source files
------------

// File: rtl/ls_buffer.sv
// ls_buffer: in-order load/store queue between the dispatcher and the LS unit.
// Entries sit in a circular buffer. Every valid entry snoops the ALU and LS
// CDB ports for the operands it still waits on. Only the head entry may issue,
// which keeps memory operations in program order.
//
// Handshake semantics:
//   dispatcher -> buffer: a write happens on a rising edge where enDispatch=1
//     and lsbFull=0. With lsbFull=1 the write is silently dropped, so the
//     dispatcher must hold the instruction itself.
//   buffer -> LS: LSworkEn is a one-cycle strobe. It fires only when LSfree=1
//     in the cycle before the edge. After a strobe the buffer waits one cycle
//     so LS has time to lower LSfree. The payload outputs keep their value
//     until the next strobe.
module ls_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enDispatch,
  input  logic [OP_W-1:0]   opCodeIn,
  input  logic [DATA_W-1:0] operandOIn,
  input  logic [DATA_W-1:0] operandTIn,
  input  logic [TAG_W-1:0]  tagOIn,
  input  logic [TAG_W-1:0]  tagTIn,
  input  logic [DATA_W-1:0] immIn,
  input  logic [TAG_W-1:0]  wrtTagIn,
  input  logic [NAME_W-1:0] wrtNameIn,
  input  logic              aluCDBen,
  input  logic [TAG_W-1:0]  aluCDBtag,
  input  logic [DATA_W-1:0] aluCDBdata,
  input  logic              lsCDBen,
  input  logic [TAG_W-1:0]  lsCDBtag,
  input  logic [DATA_W-1:0] lsCDBdata,
  input  logic              LSfree,
  output logic              lsbFull,
  output logic              LSworkEn,
  output logic [DATA_W-1:0] operandO,
  output logic [DATA_W-1:0] operandT,
  output logic [DATA_W-1:0] imm,
  output logic [TAG_W-1:0]  wrtTag,
  output logic [NAME_W-1:0] wrtName,
  output logic [OP_W-1:0]   opCode
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage, one array per field.
  logic [DEPTH-1:0]  ent_valid;
  logic [OP_W-1:0]   ent_op    [DEPTH];
  logic [DATA_W-1:0] ent_valo  [DEPTH];
  logic [TAG_W-1:0]  ent_tago  [DEPTH];
  logic [DATA_W-1:0] ent_valt  [DEPTH];
  logic [TAG_W-1:0]  ent_tagt  [DEPTH];
  logic [DATA_W-1:0] ent_imm   [DEPTH];
  logic [TAG_W-1:0]  ent_wtag  [DEPTH];
  logic [NAME_W-1:0] ent_wname [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic disp_go;
  logic issue_go;
  logic head_ready;

  // Operand values of the incoming entry after a same-cycle CDB capture.
  logic [DATA_W-1:0] in_valo;
  logic [DATA_W-1:0] in_valt;
  logic [TAG_W-1:0]  in_tago;
  logic [TAG_W-1:0]  in_tagt;

  // Full flag comes from the registered count, so a same-cycle issue does not
  // make room for a dispatch.
  assign lsbFull = (count == CW'(DEPTH));
  assign disp_go = enDispatch && !lsbFull;

  // The head is ready only from registered tags, so a capture at an edge can
  // issue at the next edge at the earliest.
  always_comb begin
    head_ready = ent_valid[head] && (ent_tago[head] == '0) && (ent_tagt[head] == '0);
  end

  // The LSworkEn term leaves one idle cycle after each strobe.
  assign issue_go = head_ready && LSfree && !LSworkEn;

  // Capture a broadcast that lands in the same cycle the entry is dispatched.
  // The ALU port takes priority when both ports carry the same tag.
  always_comb begin
    in_valo = operandOIn;
    in_tago = tagOIn;
    in_valt = operandTIn;
    in_tagt = tagTIn;
    if (tagOIn != '0) begin
      if (aluCDBen && (aluCDBtag == tagOIn)) begin
        in_valo = aluCDBdata;
        in_tago = '0;
      end else if (lsCDBen && (lsCDBtag == tagOIn)) begin
        in_valo = lsCDBdata;
        in_tago = '0;
      end
    end
    if (tagTIn != '0) begin
      if (aluCDBen && (aluCDBtag == tagTIn)) begin
        in_valt = aluCDBdata;
        in_tagt = '0;
      end else if (lsCDBen && (lsCDBtag == tagTIn)) begin
        in_valt = lsCDBdata;
        in_tagt = '0;
      end
    end
  end

  // Entry array: snoop waiting operands, retire the issued head, write at tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_op[i]    <= '0;
        ent_valo[i]  <= '0;
        ent_tago[i]  <= '0;
        ent_valt[i]  <= '0;
        ent_tagt[i]  <= '0;
        ent_imm[i]   <= '0;
        ent_wtag[i]  <= '0;
        ent_wname[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && (ent_tago[i] != '0)) begin
          if (aluCDBen && (aluCDBtag == ent_tago[i])) begin
            ent_valo[i] <= aluCDBdata;
            ent_tago[i] <= '0;
          end else if (lsCDBen && (lsCDBtag == ent_tago[i])) begin
            ent_valo[i] <= lsCDBdata;
            ent_tago[i] <= '0;
          end
        end
        if (ent_valid[i] && (ent_tagt[i] != '0)) begin
          if (aluCDBen && (aluCDBtag == ent_tagt[i])) begin
            ent_valt[i] <= aluCDBdata;
            ent_tagt[i] <= '0;
          end else if (lsCDBen && (lsCDBtag == ent_tagt[i])) begin
            ent_valt[i] <= lsCDBdata;
            ent_tagt[i] <= '0;
          end
        end
      end
      // Issue needs a valid head, and dispatch needs a free slot, so the two
      // never target the same slot in one cycle.
      if (issue_go) begin
        ent_valid[head] <= 1'b0;
      end
      if (disp_go) begin
        ent_valid[tail] <= 1'b1;
        ent_op[tail]    <= opCodeIn;
        ent_valo[tail]  <= in_valo;
        ent_tago[tail]  <= in_tago;
        ent_valt[tail]  <= in_valt;
        ent_tagt[tail]  <= in_tagt;
        ent_imm[tail]   <= immIn;
        ent_wtag[tail]  <= wrtTagIn;
        ent_wname[tail] <= wrtNameIn;
      end
    end
  end

  // Head/tail pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (issue_go) begin
        head <= head + 1'b1;
      end
      if (disp_go) begin
        tail <= tail + 1'b1;
      end
      case ({disp_go, issue_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered issue strobe and payload, held until the next issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LSworkEn <= 1'b0;
      operandO <= '0;
      operandT <= '0;
      imm      <= '0;
      wrtTag   <= '0;
      wrtName  <= '0;
      opCode   <= '0;
    end else begin
      LSworkEn <= issue_go;
      if (issue_go) begin
        operandO <= ent_valo[head];
        operandT <= ent_valt[head];
        imm      <= ent_imm[head];
        wrtTag   <= ent_wtag[head];
        wrtName  <= ent_wname[head];
        opCode   <= ent_op[head];
      end
    end
  end

endmodule

// File: tb/tb_ls_buffer.sv
// tb_ls_buffer: directed and random checks of ls_buffer against a queue-based
// reference model of the load/store queue.
module tb_ls_buffer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int NAME_W = 5;
  localparam int OP_W   = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              enDispatch;
  logic [OP_W-1:0]   opCodeIn;
  logic [DATA_W-1:0] operandOIn, operandTIn, immIn;
  logic [TAG_W-1:0]  tagOIn, tagTIn, wrtTagIn;
  logic [NAME_W-1:0] wrtNameIn;
  logic              aluCDBen, lsCDBen;
  logic [TAG_W-1:0]  aluCDBtag, lsCDBtag;
  logic [DATA_W-1:0] aluCDBdata, lsCDBdata;
  logic              LSfree;
  logic              lsbFull, LSworkEn;
  logic [DATA_W-1:0] operandO, operandT, imm;
  logic [TAG_W-1:0]  wrtTag;
  logic [NAME_W-1:0] wrtName;
  logic [OP_W-1:0]   opCode;

  ls_buffer #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .NAME_W(NAME_W), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst(rst), .enDispatch(enDispatch), .opCodeIn(opCodeIn),
    .operandOIn(operandOIn), .operandTIn(operandTIn), .tagOIn(tagOIn), .tagTIn(tagTIn),
    .immIn(immIn), .wrtTagIn(wrtTagIn), .wrtNameIn(wrtNameIn),
    .aluCDBen(aluCDBen), .aluCDBtag(aluCDBtag), .aluCDBdata(aluCDBdata),
    .lsCDBen(lsCDBen), .lsCDBtag(lsCDBtag), .lsCDBdata(lsCDBdata),
    .LSfree(LSfree), .lsbFull(lsbFull), .LSworkEn(LSworkEn),
    .operandO(operandO), .operandT(operandT), .imm(imm),
    .wrtTag(wrtTag), .wrtName(wrtName), .opCode(opCode)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: an ordered list of pending instructions.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vo;
    logic [TAG_W-1:0]  to;
    logic [DATA_W-1:0] vt;
    logic [TAG_W-1:0]  tt;
    logic [DATA_W-1:0] im;
    logic [TAG_W-1:0]  wt;
    logic [NAME_W-1:0] wn;
  } ent_t;

  ent_t exp_q[$];
  logic exp_work;
  ent_t exp_out;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_work = 1'b0;
    exp_out  = '0;
  endtask

  // Resolve one operand against the CDB ports; ALU wins on a double match.
  task automatic resolve(inout logic [DATA_W-1:0] v, inout logic [TAG_W-1:0] t);
    if (t != 0) begin
      if (aluCDBen && aluCDBtag == t) begin
        v = aluCDBdata; t = 0;
      end else if (lsCDBen && lsCDBtag == t) begin
        v = lsCDBdata; t = 0;
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit   iss;
    bit   dsp;
    ent_t e;
    iss = (exp_q.size() > 0) && (exp_q[0].to == 0) && (exp_q[0].tt == 0)
          && LSfree && !exp_work;
    dsp = enDispatch && (exp_q.size() < DEPTH);
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      resolve(e.vo, e.to);
      resolve(e.vt, e.tt);
      exp_q[i] = e;
    end
    if (iss) begin
      exp_out  = exp_q.pop_front();
      exp_work = 1'b1;
    end else begin
      exp_work = 1'b0;
    end
    if (dsp) begin
      e.op = opCodeIn; e.vo = operandOIn; e.to = tagOIn;
      e.vt = operandTIn; e.tt = tagTIn; e.im = immIn;
      e.wt = wrtTagIn; e.wn = wrtNameIn;
      resolve(e.vo, e.to);
      resolve(e.vt, e.tt);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, "_work"}, 32'(LSworkEn), 32'(exp_work));
    check({pfx, "_full"}, 32'(lsbFull), 32'(exp_q.size() == DEPTH));
    check({pfx, "_op"},   32'(opCode),   32'(exp_out.op));
    check({pfx, "_opO"},  operandO,      exp_out.vo);
    check({pfx, "_opT"},  operandT,      exp_out.vt);
    check({pfx, "_imm"},  imm,           exp_out.im);
    check({pfx, "_wtag"}, 32'(wrtTag),   32'(exp_out.wt));
    check({pfx, "_wname"},32'(wrtName),  32'(exp_out.wn));
  endtask

  // Driver tasks
  task automatic idle_inputs();
    enDispatch = 0; opCodeIn = '0; operandOIn = '0; operandTIn = '0;
    tagOIn = '0; tagTIn = '0; immIn = '0; wrtTagIn = '0; wrtNameIn = '0;
    aluCDBen = 0; aluCDBtag = '0; aluCDBdata = '0;
    lsCDBen = 0; lsCDBtag = '0; lsCDBdata = '0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vo,
                      input logic [TAG_W-1:0] to, input logic [DATA_W-1:0] vt,
                      input logic [TAG_W-1:0] tt, input logic [DATA_W-1:0] im,
                      input logic [TAG_W-1:0] wt, input logic [NAME_W-1:0] wn);
    enDispatch = 1; opCodeIn = op; operandOIn = vo; tagOIn = to;
    operandTIn = vt; tagTIn = tt; immIn = im; wrtTagIn = wt; wrtNameIn = wn;
  endtask

  task automatic cycle(input string pfx);
    model_edge();
    @(posedge clk);
    #1;
    enDispatch = 0; aluCDBen = 0; lsCDBen = 0;
    check_all(pfx);
  endtask

  // Asynchronous reset taken mid-cycle, released one edge later.
  task automatic do_reset(input string pfx);
    rst = 0;
    idle_inputs();
    #1;
    model_clear();
    check_all({pfx, "_async"});
    @(posedge clk);
    #1;
    check_all({pfx, "_held"});
    rst = 1;
  endtask

  int nexp;

  initial begin
    rst = 1;
    LSfree = 0;
    idle_inputs();
    model_clear();
    #2;
    do_reset("rst0");
    check("rst0_full_const", 32'(lsbFull), 32'd0);

    // Ready load: issue two edges after dispatch.
    LSfree = 1;
    disp(6'h23, 32'h100, 4'd0, 32'h0, 4'd0, 32'd4, 4'd3, 5'd5);
    cycle("rl_t");
    check("rl_gap", 32'(LSworkEn), 32'd0);
    cycle("rl_t1");
    check("rl_work", 32'(LSworkEn), 32'd1);
    check("rl_opO", operandO, 32'h100);
    check("rl_imm", imm, 32'd4);
    check("rl_wtag", 32'(wrtTag), 32'd3);
    check("rl_wname", 32'(wrtName), 32'd5);
    cycle("rl_after");
    check("rl_pulse", 32'(LSworkEn), 32'd0);

    // Waiting operand captured from the ALU CDB three cycles after dispatch.
    disp(6'h23, 32'h0, 4'd7, 32'h0, 4'd0, 32'd8, 4'd2, 5'd6);
    cycle("wo_d");
    cycle("wo_w1");
    cycle("wo_w2");
    aluCDBen = 1; aluCDBtag = 4'd7; aluCDBdata = 32'h2000;
    cycle("wo_cap");
    check("wo_nobypass", 32'(LSworkEn), 32'd0);
    cycle("wo_iss");
    check("wo_work", 32'(LSworkEn), 32'd1);
    check("wo_opO", operandO, 32'h2000);
    cycle("wo_after");

    // Dispatch-time capture from the LS CDB.
    disp(6'h2b, 32'h40, 4'd0, 32'h1234, 4'd9, 32'd0, 4'd1, 5'd7);
    lsCDBen = 1; lsCDBtag = 4'd9; lsCDBdata = 32'hDEAD;
    cycle("dc_d");
    cycle("dc_iss");
    check("dc_work", 32'(LSworkEn), 32'd1);
    check("dc_opT", operandT, 32'hDEAD);
    cycle("dc_after");

    // Full and wrap: nine dispatches with LS busy, then drain.
    LSfree = 0;
    for (int i = 0; i < 9; i++) begin
      disp(6'(i + 1), 32'(i * 16), 4'd0, 32'(i), 4'd0, 32'(i + 100), 4'(i), 5'(i));
      cycle("fw_fill");
      if (i >= 7) check("fw_full", 32'(lsbFull), 32'd1);
    end
    LSfree = 1;
    nexp = 0;
    for (int k = 0; k < 16; k++) begin
      cycle("fw_drain");
      if (k == 0) check("fw_full_clear", 32'(lsbFull), 32'd0);
      if (LSworkEn) begin
        check("fw_order", 32'(wrtName), 32'(nexp));
        nexp++;
      end
    end
    check("fw_count", 32'(nexp), 32'd8);

    // In-order blocking behind a waiting head.
    disp(6'h23, 32'h0, 4'd4, 32'h0, 4'd0, 32'd0, 4'd5, 5'd20);
    cycle("io_d1");
    disp(6'h23, 32'h80, 4'd0, 32'h0, 4'd0, 32'd0, 4'd6, 5'd21);
    cycle("io_d2");
    cycle("io_w1");
    check("io_block", 32'(LSworkEn), 32'd0);
    cycle("io_w2");
    aluCDBen = 1; aluCDBtag = 4'd4; aluCDBdata = 32'h4444;
    cycle("io_cap");
    cycle("io_iss1");
    check("io_first", 32'(wrtName), 32'd20);
    check("io_first_opO", operandO, 32'h4444);
    cycle("io_gap");
    cycle("io_iss2");
    check("io_second", 32'(wrtName), 32'd21);

    // Reset mid-operation with three entries queued.
    LSfree = 0;
    for (int i = 0; i < 3; i++) begin
      disp(6'h23, 32'(i), 4'd0, 32'h0, 4'd0, 32'd0, 4'd1, 5'(i + 1));
      cycle("mr_fill");
    end
    do_reset("mr");
    check("mr_opO_zero", operandO, 32'd0);
    LSfree = 1;
    for (int i = 0; i < 3; i++) begin
      cycle("mr_quiet");
      check("mr_no_issue", 32'(LSworkEn), 32'd0);
    end

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset("rnd_rst");
      LSfree = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) begin
        disp(6'($urandom), $urandom,
             ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 7)) : 4'd0,
             $urandom,
             ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 7)) : 4'd0,
             $urandom, 4'($urandom), 5'($urandom));
      end
      aluCDBen = ($urandom_range(0, 2) == 0);
      aluCDBtag = 4'($urandom_range(0, 7));
      aluCDBdata = $urandom;
      lsCDBen = ($urandom_range(0, 2) == 0);
      lsCDBtag = 4'($urandom_range(0, 7));
      lsCDBdata = $urandom;
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
